// File: rtl/shift_sub_divider_seq.sv
// Restoring shift/subtract divider; one quotient bit per enabled clock.
// Ports: clk, rst_n, ena, start, dividend, divisor -> busy, done,
// quotient, remainder, div_by_zero.
// Option macro SHIFT_SUB_DIV_ZERO_DETECT_EN: divisor 0 short-cuts to DONE
// and raises div_by_zero; otherwise div_by_zero is tied low.
module shift_sub_divider_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  // The partial remainder never exceeds WIDTH bits once stored: a kept
  // difference is below D, and the divisor-0 path only shifts the
  // dividend in, so bit WIDTH of R is always 0 and is not kept.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH:0]   shift;
  logic [WIDTH:0]   diff;
`ifdef SHIFT_SUB_DIV_ZERO_DETECT_EN
  logic             dbz_q, dbz_d;
`endif

  assign shift = {r_q, q_q[WIDTH-1]};
  assign diff  = shift - {1'b0, d_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef SHIFT_SUB_DIV_ZERO_DETECT_EN
    dbz_d   = dbz_q;
`endif
    if (ena) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (start) begin
            state_d = S_RUN;
            q_d     = dividend;
            d_d     = divisor;
            r_d     = '0;
            cnt_d   = '0;
`ifdef SHIFT_SUB_DIV_ZERO_DETECT_EN
            dbz_d   = 1'b0;
            if (divisor == '0) begin
              state_d = S_DONE;
              quot_d  = '1;
              rem_d   = dividend;
              dbz_d   = 1'b1;
            end
`endif
          end
        end
        S_RUN: begin
          if (!diff[WIDTH]) begin
            r_d = diff[WIDTH-1:0];
            q_d = {q_q[WIDTH-2:0], 1'b1};
          end else begin
            r_d = shift[WIDTH-1:0];
            q_d = {q_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            quot_d  = q_d;
            rem_d   = r_d;
            state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

`ifdef SHIFT_SUB_DIV_ZERO_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbz_q <= 1'b0;
    else        dbz_q <= dbz_d;
  end
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_shift_sub_divider_seq.sv
// Directed bench for shift_sub_divider_seq at WIDTH=8.
// Drives and samples on the falling edge; results checked by assertion.
module tb_shift_sub_divider_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  shift_sub_divider_seq #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check busy high / done low at n consecutive falling edges.
  task automatic busy_run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
      chk({tag, "_ndone"}, {7'd0, done}, 8'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    start = 1'b0;
    dividend = 8'd0;
    divisor = 8'd0;
    @(negedge clk);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_q", quotient, 8'h00);
    chk("rst_r", remainder, 8'h00);
    chk("rst_dbz", {7'd0, div_by_zero}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", {7'd0, busy}, 8'd0);

    // 200 / 7 = 28 r 4
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    busy_run("d200", 8);
    chk("d200_done", {7'd0, done}, 8'd1);
    chk("d200_nbusy", {7'd0, busy}, 8'd0);
    chk("d200_q", quotient, 8'd28);
    chk("d200_r", remainder, 8'd4);
    @(negedge clk);
    chk("d200_pulse", {7'd0, done}, 8'd0);
    chk("d200_hold_q", quotient, 8'd28);

    // 5 / 9, then 255 / 1 accepted during done
    start = 1'b1; dividend = 8'd5; divisor = 8'd9;
    @(negedge clk);
    start = 1'b0;
    busy_run("d5", 8);
    chk("d5_done", {7'd0, done}, 8'd1);
    chk("d5_q", quotient, 8'd0);
    chk("d5_r", remainder, 8'd5);
    start = 1'b1; dividend = 8'd255; divisor = 8'd1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_q_hold", quotient, 8'd0);
    busy_run("d255", 8);
    chk("d255_done", {7'd0, done}, 8'd1);
    chk("d255_q", quotient, 8'd255);
    chk("d255_r", remainder, 8'd0);
    @(negedge clk);

    // 0x5A / 0
    start = 1'b1; dividend = 8'h5A; divisor = 8'd0;
    @(negedge clk);
    start = 1'b0;
`ifdef SHIFT_SUB_DIV_ZERO_DETECT_EN
    chk("dz_nbusy", {7'd0, busy}, 8'd0);
    chk("dz_done", {7'd0, done}, 8'd1);
    chk("dz_q", quotient, 8'hFF);
    chk("dz_r", remainder, 8'h5A);
    chk("dz_flag", {7'd0, div_by_zero}, 8'd1);
    @(negedge clk);
    chk("dz_flag_hold", {7'd0, div_by_zero}, 8'd1);
`else
    busy_run("dz", 8);
    chk("dz_done", {7'd0, done}, 8'd1);
    chk("dz_q", quotient, 8'hFF);
    chk("dz_r", remainder, 8'h5A);
    chk("dz_flag", {7'd0, div_by_zero}, 8'd0);
    @(negedge clk);
`endif

    // 100 / 3 = 33 r 1, ena low 3 cycles, start pulsed mid-run
    start = 1'b1; dividend = 8'd100; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
`ifdef SHIFT_SUB_DIV_ZERO_DETECT_EN
    chk("d100_dbz_clr", {7'd0, div_by_zero}, 8'd0);
`endif
    for (int i = 1; i <= 11; i++) begin
      ena = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
      start = (i == 7) ? 1'b1 : 1'b0;
      if (i == 7) begin
        dividend = 8'd50; divisor = 8'd5;
      end
      @(negedge clk);
      chk($sformatf("d100_done_e%0d", i), {7'd0, done},
          (i == 11) ? 8'd1 : 8'd0);
    end
    start = 1'b0;
    ena = 1'b1;
    chk("d100_q", quotient, 8'd33);
    chk("d100_r", remainder, 8'd1);
    @(negedge clk);
    chk("d100_no_queue_busy", {7'd0, busy}, 8'd0);
    chk("d100_no_queue_done", {7'd0, done}, 8'd0);

    // 200 / 7 aborted by reset after step 3
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_pre", {7'd0, busy}, 8'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_done", {7'd0, done}, 8'd0);
    chk("abort_q", quotient, 8'd0);
    chk("abort_r", remainder, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", {7'd0, busy | done}, 8'd0);
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    busy_run("re200", 8);
    chk("re200_done", {7'd0, done}, 8'd1);
    chk("re200_q", quotient, 8'd28);
    chk("re200_r", remainder, 8'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sub_divider_seq.md
# shift_sub_divider_seq

Iterative controller that sequences one shift stage and one subtract stage to perform unsigned restoring division, one quotient bit per clock. Sits behind the shifter/subtractor datapath inside the user project top. It accepts operands on a start/busy/done handshake and holds results until the next accepted start.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width; legal values are 2 to 16.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ena` input 1: design-select enable. When low, all state holds.
- `start` input 1: request. Sampled on the rising edge only when `ena`=1.
- `dividend` input WIDTH: numerator. Captured on the accept edge.
- `divisor` input WIDTH: denominator. Captured on the accept edge.
- `busy` output 1: high while iterating (state RUN).
- `done` output 1: one-cycle pulse (state DONE); results are valid from this cycle on.
- `quotient` output WIDTH: registered result.
- `remainder` output WIDTH: registered result.
- `div_by_zero` output 1: registered flag; see Configuration.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- Reset (async, `rst_n`=0):
  - state goes to IDLE;
  - `busy`, `done`, `div_by_zero` are 0;
  - `quotient` and `remainder` are 0;
  - the iteration counter is 0.
- Accept: `start`=1 and `ena`=1 in IDLE or DONE at a rising edge. On accept:
  - Q is loaded with `dividend`, D with `divisor`, R (WIDTH+1 bits) with 0;
  - counter is set to 0; `div_by_zero` is set to 0;
  - state goes to RUN.
- In RUN, each edge with `ena`=1 performs one step:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} − {0, D}, computed WIDTH+1 bits wide;
  - if T[WIDTH]=0: R←T and Q←{Q[WIDTH-2:0],1};
  - else: R←{R[WIDTH-1:0],Q[WIDTH-1]} and Q←{Q[WIDTH-2:0],0};
  - counter increments.
- After step WIDTH (counter = WIDTH−1 on that edge):
  - `quotient`←Q, `remainder`←R[WIDTH-1:0];
  - state goes to DONE.
- DONE lasts one enabled cycle, then returns to IDLE unless a new accept occurs.
- `start` in RUN is ignored and is not queued.
- `quotient`/`remainder` are visible only through their output registers. They change only at the DONE transition or on reset, never mid-iteration.
- Divisor 0 through the normal path gives `quotient`=all ones and `remainder`=`dividend`.

## Timing
- Accept at edge E0 → `busy`=1 after E0.
- Steps occur at E1..E_WIDTH. After E_WIDTH: `busy`=0, `done`=1, results valid.
- Latency from accept to `done` is WIDTH enabled cycles. `busy` is high for exactly WIDTH enabled cycles.
- Back-to-back: `start`=1 while `done`=1 is accepted. Throughput is one result per WIDTH+1 cycles.
- `ena`=0 at any edge freezes state, counter, Q, R and outputs. A `done` pulse stretches across ena-low cycles.
- `rst_n` low mid-RUN aborts immediately: all outputs go to their reset values. No partial result is ever presented.

## Configuration
- Macro: `SHIFT_SUB_DIV_ZERO_DETECT_EN`.
- Defined:
  - an accept with `divisor`=0 goes directly to DONE after E0, with no RUN cycles;
  - `quotient`=all ones, `remainder`=`dividend`, `div_by_zero`=1;
  - `div_by_zero` stays 1 until the next accept or reset.
- Undefined:
  - divisor 0 runs the full WIDTH steps and yields the same `quotient`/`remainder`;
  - `div_by_zero` is tied to 0.

## Test plan
All cases use WIDTH=8.
- Reset then idle: `rst_n` pulse low → `busy`=0, `done`=0, `quotient`=0x00, `remainder`=0x00, `div_by_zero`=0.
- 200/7 with start pulse:
  - `busy` high 8 cycles, then `done` for 1 cycle;
  - `quotient`=28, `remainder`=4.
- 5/9 then back-to-back 255/1, with start held during the first `done` cycle:
  - first result: q=0, r=5;
  - second accepted immediately: q=255, r=0.
- 0x5A/0:
  - macro defined: `done` 1 cycle after accept, q=0xFF, r=0x5A, `div_by_zero`=1;
  - macro undefined: `done` after 8 cycles, q=0xFF, r=0x5A, `div_by_zero`=0.
- 100/3 with `ena` low for 3 cycles during RUN, and `start` pulsed mid-RUN:
  - `done` arrives 11 cycles after accept;
  - q=33, r=1;
  - the mid-RUN start is ignored.
- 200/7 with `rst_n` low after step 3:
  - outputs go to reset values at once and state is IDLE;
  - a subsequent 200/7 gives q=28, r=4.
